pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
- Stall/flush controller for the 5-stage 16-bit pipeline.
- Sits beside the forwarding unit and covers the hazards forwarding cannot resolve:
  - load-use (EX-stage load feeding the ID-stage instruction),
  - unified-RAM structural conflict,
  - taken-branch flush,
  - interrupt entry sequencing (pipeline drain, EPC capture).
- Drives hold/flush controls of PC, IF/ID and ID/EX registers; keeps a saturating bubble counter for debug.

Parameters:
- PC_W, 16, PC/data width
- REG_ADDR_W, 3, GPR address width
- DRAIN_CYCLES, 3, cycles fetch is suppressed before interrupt jump (min 1)
- CNT_W, 16, bubble counter width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset
- reg1_addr  in  REG_ADDR_W  ID source A GPR
- reg2_addr  in  REG_ADDR_W  ID source B GPR
- op1_mux_op  in  3  ID operand-A select: 0 REGA, 1 SP, 2 T, 3 IH, else none
- op2_mux_op  in  3  ID operand-B select: 0 REGB, else none
- id_reads_ih  in  1  ID instruction reads IH (MFIH)
- ieo_reg_op  in  3  ID/EX dest class: 0 NOP, 1 REG, 2 SP, 3 T, 4 IH
- ieo_wb_addr  in  REG_ADDR_W  ID/EX dest GPR
- ieo_wb_data_op  in  3  ID/EX WB source: 0 ALU, 1 MEM, 2 IH, 3 PC, 4 NOP
- mem_conflict  in  1  EX/MEM data access targets instruction RAM this cycle
- branch_taken  in  1  ID resolved taken branch/jump
- ifid_pc  in  PC_W  PC of instruction in IF/ID
- int_req  in  1  level interrupt request, held until int_ack
- int_enable  in  1  IH global enable bit
- pc_hold  out  1  PC keeps value
- ifid_hold  out  1  IF/ID keeps value
- ifid_flush  out  1  IF/ID loads NOP
- idex_flush  out  1  ID/EX loads NOP (bubble)
- int_pc_sel  out  1  PC loads interrupt vector
- int_ack  out  1  one-cycle acknowledge
- int_epc  out  PC_W  registered return PC
- bubble_cnt  out  CNT_W  saturating bubble counter

Behaviour:
- **Reset and clocking**
  - Synchronous active-high reset on clk (`rst`).
  - Reset values: state IDLE, drain counter 0, int_epc 0, bubble_cnt 0.
  - All combinational outputs are 0 while rst=1.
- **load_use** (combinational). Asserted when ieo_wb_data_op==1 and any of:
  - ieo_reg_op==1 and op1_mux_op==0 and reg1_addr==ieo_wb_addr;
  - ieo_reg_op==1 and op2_mux_op==0 and reg2_addr==ieo_wb_addr;
  - ieo_reg_op==2 and op1_mux_op==1;
  - ieo_reg_op==3 and op1_mux_op==2;
  - ieo_reg_op==4 and (id_reads_ih or op1_mux_op==3).
- **FSM states:** IDLE, DRAIN, JUMP.
- **IDLE**, evaluated in priority order:
  1. mem_conflict: pc_hold=1, ifid_flush=1. Fetched word is invalid; the ID instruction proceeds.
  2. load_use: pc_hold=1, ifid_hold=1, idex_flush=1. Exactly one bubble; no state change.
  3. branch_taken: ifid_flush=1.
  4. Otherwise no controls asserted.
- **Interrupt accept** (from IDLE)
  - Condition: int_req & int_enable & ~mem_conflict & ~load_use & ~branch_taken.
  - Actions: go to DRAIN, latch int_epc<=ifid_pc, load drain counter DRAIN_CYCLES-1.
  - The acceptance cycle itself asserts pc_hold=1 and ifid_flush=1.
  - If the condition fails, the request stays pending and is re-evaluated next cycle.
- **DRAIN**
  - Outputs: pc_hold=1, ifid_flush=1.
  - Drain counter decrements each cycle; at 0 go to JUMP.
  - mem_conflict and load_use still apply on top of DRAIN outputs (OR-ed).
  - branch_taken is ignored (IF/ID holds NOP).
- **JUMP** (1 cycle)
  - Outputs: int_pc_sel=1, int_ack=1, ifid_flush=1, pc_hold=0. Then return to IDLE.
  - int_req still high the following IDLE cycle is not a new request; the source drops it on int_ack (bench rule).
- **Timing**
  - Interrupt entry: acceptance to int_pc_sel = DRAIN_CYCLES+1 cycles.
  - int_epc is stable from the cycle after acceptance until the next acceptance.
- **bubble_cnt**
  - +1 on each cycle with (ifid_flush | idex_flush).
  - Saturates at all-ones (no wrap); cleared only by rst.
- **Reset mid-operation:** rst in DRAIN/JUMP returns to IDLE next edge with no int_ack and int_epc=0.
- **Invariant:** ifid_hold and ifid_flush are never both 1. When both would be 1 (load_use with DRAIN or mem_conflict), ifid_flush wins and ifid_hold=0.

Test Plan:
- Load-use: ieo_wb_data_op=1, ieo_reg_op=1, ieo_wb_addr=3, reg1_addr=3, op1_mux_op=0 -> same cycle pc_hold=1, ifid_hold=1, idex_flush=1; next cycle with ieo_reg_op=0, all 0; bubble_cnt=1.
- Non-hazard: same as above but ieo_wb_data_op=0 (ALU) -> no stall. Also ieo_reg_op=2, op1_mux_op=1, ieo_wb_data_op=1 -> stall.
- Interrupt: IDLE, int_req=1, int_enable=1, ifid_pc=0x0040, DRAIN_CYCLES=3 ->
  - int_epc=0x0040;
  - pc_hold=1 for 4 cycles;
  - 5th cycle int_pc_sel=1, int_ack=1;
  - then IDLE.
- Interrupt deferral: int_req=1 with branch_taken=1 -> only ifid_flush that cycle, no ack. Accepted next cycle with branch_taken=0. int_enable=0 -> never accepted.
- Priority: mem_conflict=1 with load_use -> pc_hold=1, ifid_flush=1, ifid_hold=0, idex_flush=1.
- Reset mid-DRAIN: rst=1 on 2nd DRAIN cycle -> outputs 0, no int_ack ever, int_epc=0. bubble_cnt forced to 0xFFFF stays 0xFFFF under further flushes.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Stall/flush controller for the 5-stage 16-bit pipeline. It handles the
// hazards that operand forwarding cannot resolve:
//   - load-use: a load in EX whose result the ID-stage instruction needs,
//   - unified-RAM structural conflict: the MEM-stage data access takes the
//     instruction RAM, so this cycle's fetch is lost,
//   - taken branch/jump resolved in ID: the wrong-path fetch is squashed,
//   - interrupt entry: fetch is suppressed for DRAIN_CYCLES cycles so that
//     the older instructions retire, then the PC is redirected to the vector.
// It also keeps a saturating count of bubble cycles for debug.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   reg1_addr       ID source A GPR
//   reg2_addr       ID source B GPR
//   op1_mux_op      ID operand-A select (0 REGA, 1 SP, 2 T, 3 IH, else none)
//   op2_mux_op      ID operand-B select (0 REGB, else none)
//   id_reads_ih     ID instruction reads IH (MFIH)
//   ieo_reg_op      ID/EX destination class (0 NOP, 1 REG, 2 SP, 3 T, 4 IH)
//   ieo_wb_addr     ID/EX destination GPR
//   ieo_wb_data_op  ID/EX write-back source (0 ALU, 1 MEM, 2 IH, 3 PC, 4 NOP)
//   mem_conflict    EX/MEM data access targets the instruction RAM
//   branch_taken    ID resolved a taken branch/jump
//   ifid_pc         PC of the instruction held in IF/ID
//   int_req         level interrupt request, held until int_ack
//   int_enable      IH global interrupt enable
//   pc_hold         PC keeps its value
//   ifid_hold       IF/ID keeps its value
//   ifid_flush      IF/ID loads a NOP
//   idex_flush      ID/EX loads a NOP (bubble)
//   int_pc_sel      PC loads the interrupt vector
//   int_ack         one-cycle interrupt acknowledge
//   int_epc         registered return PC captured on interrupt acceptance
//   bubble_cnt      saturating count of cycles with ifid_flush or idex_flush
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
   parameter int PC_W         = 16,
   parameter int REG_ADDR_W   = 3,
   parameter int DRAIN_CYCLES = 3,
   parameter int CNT_W        = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [REG_ADDR_W-1:0] reg1_addr,
   input  logic [REG_ADDR_W-1:0] reg2_addr,
   input  logic [2:0]            op1_mux_op,
   input  logic [2:0]            op2_mux_op,
   input  logic                  id_reads_ih,
   input  logic [2:0]            ieo_reg_op,
   input  logic [REG_ADDR_W-1:0] ieo_wb_addr,
   input  logic [2:0]            ieo_wb_data_op,
   input  logic                  mem_conflict,
   input  logic                  branch_taken,
   input  logic [PC_W-1:0]       ifid_pc,
   input  logic                  int_req,
   input  logic                  int_enable,
   output logic                  pc_hold,
   output logic                  ifid_hold,
   output logic                  ifid_flush,
   output logic                  idex_flush,
   output logic                  int_pc_sel,
   output logic                  int_ack,
   output logic [PC_W-1:0]       int_epc,
   output logic [CNT_W-1:0]      bubble_cnt
);

   // ------------------------------------------------------------------
   // Encodings of the decode fields
   // ------------------------------------------------------------------
   localparam logic [2:0] OP1_REGA = 3'd0;
   localparam logic [2:0] OP1_SP   = 3'd1;
   localparam logic [2:0] OP1_T    = 3'd2;
   localparam logic [2:0] OP1_IH   = 3'd3;
   localparam logic [2:0] OP2_REGB = 3'd0;

   localparam logic [2:0] DST_REG  = 3'd1;
   localparam logic [2:0] DST_SP   = 3'd2;
   localparam logic [2:0] DST_T    = 3'd3;
   localparam logic [2:0] DST_IH   = 3'd4;

   localparam logic [2:0] WB_MEM   = 3'd1;

   // Drain counter holds DRAIN_CYCLES-1 down to 0; at least one bit wide.
   localparam int DCNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [DCNT_W-1:0] DRAIN_LOAD = DCNT_W'(DRAIN_CYCLES - 1);
   localparam logic [DCNT_W-1:0] DRAIN_ONE  = DCNT_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_JUMP  = 2'd2
   } state_t;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   state_t            state_q,  state_d;
   logic [DCNT_W-1:0] drain_q,  drain_d;
   logic [PC_W-1:0]   epc_q,    epc_d;
   logic [CNT_W-1:0]  bubble_q, bubble_d;

   // ------------------------------------------------------------------
   // Load-use detection
   // A load (write-back from MEM) sitting in EX whose destination is a
   // source of the ID instruction. The loaded value only exists after
   // MEM, so forwarding cannot cover it and ID must wait one cycle.
   // ------------------------------------------------------------------
   logic is_load;
   logic lu_rega;
   logic lu_regb;
   logic lu_sp;
   logic lu_t;
   logic lu_ih;
   logic load_use;

   assign is_load  = (ieo_wb_data_op == WB_MEM);
   assign lu_rega  = (ieo_reg_op == DST_REG) && (op1_mux_op == OP1_REGA) &&
                     (reg1_addr == ieo_wb_addr);
   assign lu_regb  = (ieo_reg_op == DST_REG) && (op2_mux_op == OP2_REGB) &&
                     (reg2_addr == ieo_wb_addr);
   assign lu_sp    = (ieo_reg_op == DST_SP) && (op1_mux_op == OP1_SP);
   assign lu_t     = (ieo_reg_op == DST_T)  && (op1_mux_op == OP1_T);
   assign lu_ih    = (ieo_reg_op == DST_IH) &&
                     (id_reads_ih || (op1_mux_op == OP1_IH));
   assign load_use = is_load && (lu_rega || lu_regb || lu_sp || lu_t || lu_ih);

   // An interrupt is only taken on a quiet cycle so that the captured
   // return PC belongs to an instruction that has not yet started and
   // is not on a squashed path.
   logic int_accept;
   assign int_accept = int_req && int_enable && !mem_conflict &&
                       !load_use && !branch_taken;

   // ------------------------------------------------------------------
   // Next-state and control outputs
   // ------------------------------------------------------------------
   logic pc_hold_c;
   logic ifid_hold_c;
   logic ifid_flush_c;
   logic idex_flush_c;
   logic int_pc_sel_c;
   logic int_ack_c;

   always_comb begin
      state_d      = state_q;
      drain_d      = drain_q;
      epc_d        = epc_q;
      pc_hold_c    = 1'b0;
      ifid_hold_c  = 1'b0;
      ifid_flush_c = 1'b0;
      idex_flush_c = 1'b0;
      int_pc_sel_c = 1'b0;
      int_ack_c    = 1'b0;

      if (!rst) begin
         case (state_q)
            ST_IDLE: begin
               // Lost fetch: keep PC so the same word is refetched, and
               // turn the garbage word in IF/ID into a NOP.
               if (mem_conflict) begin
                  pc_hold_c    = 1'b1;
                  ifid_flush_c = 1'b1;
               end
               // Load-use: freeze PC and IF/ID, insert a single bubble.
               if (load_use) begin
                  pc_hold_c    = 1'b1;
                  ifid_hold_c  = 1'b1;
                  idex_flush_c = 1'b1;
               end
               // A stalled branch is re-resolved next cycle, so only a
               // free-running branch squashes the wrong-path fetch.
               if (branch_taken && !mem_conflict && !load_use) begin
                  ifid_flush_c = 1'b1;
               end
               if (int_accept) begin
                  pc_hold_c    = 1'b1;
                  ifid_flush_c = 1'b1;
                  epc_d        = ifid_pc;
                  drain_d      = DRAIN_LOAD;
                  state_d      = ST_DRAIN;
               end
            end

            ST_DRAIN: begin
               // IF/ID already holds a NOP, so a branch cannot be in ID.
               pc_hold_c    = 1'b1;
               ifid_flush_c = 1'b1;
               if (load_use) begin
                  ifid_hold_c  = 1'b1;
                  idex_flush_c = 1'b1;
               end
               if (drain_q == '0) begin
                  state_d = ST_JUMP;
               end else begin
                  drain_d = drain_q - DRAIN_ONE;
               end
            end

            ST_JUMP: begin
               int_pc_sel_c = 1'b1;
               int_ack_c    = 1'b1;
               ifid_flush_c = 1'b1;
               state_d      = ST_IDLE;
            end

            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      // Saturating bubble counter.
      bubble_d = bubble_q;
      if ((ifid_flush_c || idex_flush_c) && (bubble_q != {CNT_W{1'b1}})) begin
         bubble_d = bubble_q + CNT_W'(1);
      end
   end

   // Flush has precedence over hold on IF/ID: the register cannot both
   // keep its value and load a NOP.
   assign pc_hold    = pc_hold_c;
   assign ifid_hold  = ifid_hold_c && !ifid_flush_c;
   assign ifid_flush = ifid_flush_c;
   assign idex_flush = idex_flush_c;
   assign int_pc_sel = int_pc_sel_c;
   assign int_ack    = int_ack_c;
   assign int_epc    = epc_q;
   assign bubble_cnt = bubble_q;

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         drain_q  <= '0;
         epc_q    <= '0;
         bubble_q <= '0;
      end else begin
         state_q  <= state_d;
         drain_q  <= drain_d;
         epc_q    <= epc_d;
         bubble_q <= bubble_d;
      end
   end

endmodule
